// File: rtl/lsu_mem_if_pkg.sv
// lsu_mem_if_pkg: shared FSM state type, access-size codes and defaults for the load/store unit.
package lsu_mem_if_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int TIMEOUT_DEFAULT = 255;
    function automatic logic f3_supported(input logic [2:0] f3);
        return f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane enables, store data replication and load data right-shift.
module lsu_lane_align
    import lsu_mem_if_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [3:0]            be,
    output logic [DATA_WIDTH-1:0] wdata_rep,
    output logic [DATA_WIDTH-1:0] rdata_shift
);
    logic [1:0] off;
    // misaligned halves/words are truncated to their natural boundary
    always_comb begin
        off = size == SZ_W ? 2'b00 : size == SZ_H ? {offset[1], 1'b0} : offset;
        be = size == SZ_W ? 4'b1111 : size == SZ_H ? 4'b0011 << off : 4'b0001 << off;
        wdata_rep = size == SZ_W ? wdata : size == SZ_H ? DATA_WIDTH'({2{wdata[15:0]}}) : DATA_WIDTH'({4{wdata[7:0]}});
        rdata_shift = rdata >> {off, 3'b000};
    end
endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit memory interface FSM; define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state, state_n;
    logic                  we_q, err_q, err_n, bad, tmo, accept;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_sh, wrep;
    logic [3:0]            be;
    logic [CW-1:0]         cnt;

    lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size(size_q), .offset(addr_q[1:0]), .wdata(wdata_q), .rdata(mem_rdata),
        .be(be), .wdata_rep(wrep), .rdata_shift(rdata_sh)
    );

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        bad = !f3_supported(req_funct3) || (req_funct3[1:0] == SZ_H && req_addr[0]) ||
              (req_funct3[1:0] == SZ_W && req_addr[1:0] != 2'b00);
`else
        bad = !f3_supported(req_funct3);
`endif
    end

    assign accept = req_valid && state == IDLE;
    assign tmo    = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            IDLE: if (req_valid) begin
                state_n = bad ? RESP : REQ;
                err_n   = bad;
            end
            REQ: if (mem_gnt) state_n = we_q ? RESP : WAIT;
                 else if (tmo) begin state_n = RESP; err_n = 1'b1; end
            WAIT: if (mem_rvalid) state_n = RESP;
                  else if (tmo) begin state_n = RESP; err_n = 1'b1; end
            RESP: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            err_q <= err_n;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_funct3[1:0];
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == WAIT && mem_rvalid) rdata_q <= rdata_sh;
            cnt <= (state_n == state && (state == REQ || state == WAIT)) ? cnt + 1'b1 : '0;
        end
    end

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;
    assign stall     = accept || state == REQ || state == WAIT;
    assign mem_req   = state == REQ;
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_be    = mem_req ? be : 4'b0000;
    assign mem_wdata = wrep;
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed transactions checked against a transaction-level model of the unit.
module tb_lsu_mem_if;
    localparam int TMO = 255;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_we = 0, mem_gnt = 0, mem_rvalid = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
    logic        req_ready, rsp_valid, rsp_err, stall, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    lsu_mem_if dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0, pass_cnt = 0;
    logic        exp_we, exp_err, exp_load_ok;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_shift, last;
    int          exp_lat;
    int          r_lat, r_rq;
    logic        r_err;
    logic [3:0]  r_be;
    logic [31:0] r_rdata, r_addr, r_wd;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic set_model(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rw);
        int off;
        logic [1:0] sz;
        sz = f3[1:0];
        off = sz == 2'b10 ? 0 : sz == 2'b01 ? int'(a & 2) : int'(a & 3);
        exp_we = we;
        exp_addr = a & ~32'h3;
        exp_be = sz == 2'b10 ? 4'hF : sz == 2'b01 ? 4'h3 << off : 4'h1 << off;
        exp_wdata = sz == 2'b10 ? wd : sz == 2'b01 ? {2{wd[15:0]}} : {4{wd[7:0]}};
        exp_shift = rw >> (8 * off);
        exp_err = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0)) exp_err = 1;
`endif
    endtask

    // gd/rd: cycles of memory wait before grant / read data; >= TMO means never
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rw, input int gd, rd);
        int gcnt, rcnt;
        logic granted, ok, bad;
        set_model(we, f3, a, wd, rw);
        bad = exp_err;
        exp_err = bad || gd >= TMO || (!we && rd >= TMO);
        exp_load_ok = !we && !exp_err;
        exp_lat = bad ? 1 : gd >= TMO ? TMO + 1 : we ? 2 + gd : rd >= TMO ? 2 + gd + TMO : 3 + gd + rd;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        ok = stall && req_ready && !rsp_valid;
        @(posedge clk); #1;
        req_valid = 0;
        r_lat = 0; r_rq = 0; r_err = 0; r_be = 0; r_rdata = 0; r_addr = 0; r_wd = 0;
        gcnt = 0; rcnt = 0; granted = 0;
        while (r_lat < 1000) begin
            @(negedge clk);
            r_lat++;
            mem_gnt = 0; mem_rvalid = 0;
            if (rsp_valid) begin
                r_err = rsp_err; r_rdata = rsp_rdata;
                ok = ok && !stall && !mem_req;
                break;
            end
            ok = ok && stall;
            if (mem_req) begin
                r_rq++;
                mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
                if (gcnt == gd) begin
                    mem_gnt = 1; granted = 1;
                    r_be = mem_be; r_addr = mem_addr; r_wd = mem_wdata;
                end
                gcnt++;
            end else if (granted) begin
                if (rcnt == rd) begin mem_rvalid = 1; mem_rdata = rw; end
                rcnt++;
            end
        end
        mem_gnt = 0; mem_rvalid = 0;
        chk("latency", r_lat, exp_lat);
        chk("stall_ready_seq", ok, 1);
    endtask

    initial begin
        last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = 0;
                chk("reset_outputs", {rsp_valid, rsp_err, stall, mem_req, mem_we, mem_be, req_ready}, 10'b0000000001);
                chk("reset_data", {rsp_rdata, mem_addr}, 64'h0);
            end else begin
                if (mem_req) begin
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_be", mem_be, exp_be);
                    chk("mem_we", mem_we, exp_we);
                    chk("mem_wdata", mem_wdata, exp_wdata);
                end
                if (rsp_valid) begin
                    logic [31:0] nxt;
                    nxt = exp_load_ok ? exp_shift : last;
                    chk("rsp_rdata", rsp_rdata, nxt);
                    chk("rsp_err", rsp_err, exp_err);
                    last = nxt;
                end else chk("rdata_hold", rsp_rdata, last);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1;

        txn(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0);
        chk("lw_lat", r_lat, 3); chk("lw_rdata", r_rdata, 32'hDEADBEEF); chk("lw_be", r_be, 4'b1111); chk("lw_err", r_err, 0);

        txn(1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0);
        chk("sb_addr", r_addr, 32'h100); chk("sb_be", r_be, 4'b1000);
        chk("sb_wdata", r_wd, 32'hA5A5A5A5); chk("sb_err", r_err, 0); chk("sb_lat", r_lat, 2);
        chk("sb_rdata_kept", r_rdata, 32'hDEADBEEF);

        txn(0, 3'b101, 32'h202, 0, 32'h8001FFFF, 0, 0);
        chk("lhu_low", r_rdata[15:0], 16'h8001); chk("lhu_full", r_rdata, 32'h00008001);

        txn(0, 3'b001, 32'h101, 0, 32'h11223344, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_err", r_err, 1); chk("lh_mis_noreq", r_rq, 0);
`else
        chk("lh_mis_be", r_be, 4'b0011); chk("lh_mis_err", r_err, 0);
`endif

        txn(1, 3'b001, 32'h106, 32'h1234BEEF, 0, 2, 0);
        chk("sh_be", r_be, 4'b1100); chk("sh_wdata", r_wd, 32'hBEEFBEEF); chk("sh_lat", r_lat, 4);

        txn(0, 3'b000, 32'h1FD, 0, 32'hCAFEF00D, 1, 3);
        chk("lb_addr", r_addr, 32'h1FC); chk("lb_rdata", r_rdata, 32'h00CAFEF0); chk("lb_lat", r_lat, 7);

        txn(1, 3'b010, 32'h40, 32'h01020304, 0, 0, 0);
        txn(0, 3'b011, 32'h80, 0, 32'h99999999, 0, 0);
        chk("f3_011_err", r_err, 1); chk("f3_011_lat", r_lat, 1); chk("f3_011_noreq", r_rq, 0);
        txn(1, 3'b111, 32'h84, 32'h55, 0, 0, 0);
        chk("f3_111_err", r_err, 1);
        txn(0, 3'b110, 32'h88, 0, 32'h77777777, 0, 0);

        txn(0, 3'b010, 32'h103, 0, 32'h0BADF00D, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_err", r_err, 1);
`else
        chk("lw_mis_be", r_be, 4'b1111); chk("lw_mis_rdata", r_rdata, 32'h0BADF00D);
`endif

        txn(0, 3'b010, 32'h500, 0, 32'h600DCAFE, 1000, 0);
        chk("gnt_tmo_err", r_err, 1); chk("gnt_tmo_reqcyc", r_rq, TMO); chk("gnt_tmo_lat", r_lat, TMO + 1);
        @(negedge clk) chk("gnt_tmo_req_low", mem_req, 0);

        txn(0, 3'b010, 32'h504, 0, 32'h13579BDF, TMO - 1, 0);
        chk("gnt_edge_err", r_err, 0); chk("gnt_edge_rdata", r_rdata, 32'h13579BDF);

        txn(0, 3'b100, 32'h508, 0, 32'hFFFFFFFF, 0, 1000);
        chk("rv_tmo_err", r_err, 1); chk("rv_tmo_lat", r_lat, TMO + 2); chk("rv_tmo_kept", r_rdata, 32'h13579BDF);

        set_model(0, 3'b010, 32'h300, 0, 32'h5555AAAA);
        exp_load_ok = 1;
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300;
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk) chk("rst_test_req", mem_req, 1);
        mem_gnt = 1;
        @(posedge clk); #1 mem_gnt = 0;
        @(negedge clk) chk("rst_test_wait", {mem_req, stall, rsp_valid}, 3'b010);
        #2 rst_n = 0;
        #1 chk("async_reset", {stall, req_ready, rsp_valid, mem_req}, 4'b0100);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1;
        mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
        repeat (3) @(negedge clk) chk("post_reset_ignore", {rsp_valid, stall, req_ready, mem_req}, 4'b0010);
        mem_rvalid = 0;

        txn(0, 3'b001, 32'h402, 0, 32'hABCD1234, 0, 0);
        chk("recover_rdata", r_rdata, 32'h0000ABCD);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
